// File: rtl/trng_ctrl.sv
// Ring-oscillator TRNG sequencer: warm-up, optional von Neumann debiasing,
// word packing onto a valid/ready port, and a repetition-count health test.
//
// state   | meaning
// IDLE    | TRNG off, waiting for enable
// WARMUP  | TRNG on, output ignored while it settles
// COLLECT | sampling trng_bit, packing accepted bits
// HOLD    | full word presented, waiting for rd_ready
// FAIL    | health test tripped, TRNG off until enable drops
module trng_ctrl #(
    parameter int WIDTH         = 32,
    parameter int WARMUP_CYCLES = 64,
    parameter int RCT_LIMIT     = 32,
    parameter int DEBIAS        = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic             trng_en,
    input  logic             trng_bit,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             health_fail,
    output logic             busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WARMUP  = 3'd1;
    localparam logic [2:0] S_COLLECT = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_FAIL    = 3'd4;

    localparam int WW = $clog2(WARMUP_CYCLES + 1);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(RCT_LIMIT + 1);
    localparam int SW = WIDTH - 1;

    localparam logic [WW-1:0] WARM_END = WW'(WARMUP_CYCLES);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [RW-1:0] RCT_MAX  = RW'(RCT_LIMIT);

    logic [2:0]    state, state_nxt;
    logic [WW-1:0] warm_cnt;
    logic [BW-1:0] bit_cnt;
    logic [RW-1:0] run_cnt, run_nxt;
    logic          last_bit;
    logic          pair_phase;
    logic          pair_first;
    logic [SW-1:0] shift_reg;
    logic          acc_valid;
    logic          acc_bit;
    logic          rct_trip;
    logic          word_done;
    logic          sampling;

    always_comb begin
        run_nxt   = run_cnt;
        acc_valid = 1'b1;
        acc_bit   = trng_bit;
        if (run_cnt == '0 || trng_bit != last_bit) begin
            run_nxt = RW'(1);
        end else if (run_cnt != RCT_MAX) begin
            run_nxt = run_cnt + RW'(1);
        end
        rct_trip = (run_nxt == RCT_MAX);

        // Second sample of a differing pair: the first sample is the output bit.
        if (DEBIAS != 0) begin
            acc_valid = pair_phase && (pair_first != trng_bit);
            acc_bit   = pair_first;
        end
        word_done = acc_valid && (bit_cnt == BIT_LAST);

        state_nxt = state;
        case (state)
            S_IDLE:    if (enable) state_nxt = S_WARMUP;
            S_WARMUP: begin
                if (!enable)                    state_nxt = S_IDLE;
                else if (warm_cnt == WARM_END)  state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
                if (!enable)        state_nxt = S_IDLE;
                else if (rct_trip)  state_nxt = S_FAIL;
                else if (word_done) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (!enable)        state_nxt = S_IDLE;
                else if (rd_ready)  state_nxt = S_COLLECT;
            end
            S_FAIL:    if (!enable) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase

        sampling = (state == S_COLLECT) && (state_nxt == S_COLLECT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            warm_cnt    <= '0;
            bit_cnt     <= '0;
            run_cnt     <= '0;
            last_bit    <= 1'b0;
            pair_phase  <= 1'b0;
            pair_first  <= 1'b0;
            shift_reg   <= '0;
            trng_en     <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            health_fail <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            trng_en     <= (state_nxt == S_WARMUP) || (state_nxt == S_COLLECT) ||
                           (state_nxt == S_HOLD);
            busy        <= (state_nxt != S_IDLE);
            health_fail <= (state_nxt == S_FAIL);
            rd_valid    <= (state_nxt == S_HOLD);

            if (state == S_WARMUP && state_nxt == S_WARMUP) begin
                warm_cnt <= warm_cnt + WW'(1);
            end else begin
                warm_cnt <= '0;
            end

            if (state == S_COLLECT && state_nxt == S_HOLD) begin
                rd_data <= {shift_reg, acc_bit};
            end

            // Any exit from COLLECT drops the partial word and restarts health/pair state.
            if (sampling) begin
                run_cnt  <= run_nxt;
                last_bit <= trng_bit;
                if (DEBIAS != 0) begin
                    pair_phase <= !pair_phase;
                    if (!pair_phase) pair_first <= trng_bit;
                end
                if (acc_valid) begin
                    shift_reg <= SW'({shift_reg, acc_bit});
                    bit_cnt   <= bit_cnt + BW'(1);
                end
            end else begin
                run_cnt    <= '0;
                bit_cnt    <= '0;
                pair_phase <= 1'b0;
                shift_reg  <= '0;
            end
        end
    end

endmodule
